// File: rtl/laser_pkg.sv
// laser_pkg: shared definitions for the tower laser block.
//   state_t          - targeting FSM states
//   SCREEN_W/H       - visible VGA area used to clip the hit marker
//   X_MSB/X_LSB/Y_MSB - field positions inside a 15-bit {x, y} coordinate
//   DEF_LASER_COLOUR - default marker colour (RRRGGGBBB)
//   abs9()           - magnitude of a 9-bit signed distance
package laser_pkg;

  typedef enum logic [2:0] {IDLE, SCAN, FIRE, DRAW, DONE} state_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int X_MSB = 14;
  localparam int X_LSB = 7;
  localparam int Y_MSB = 6;

  localparam logic [8:0] DEF_LASER_COLOUR = 9'b111000000;

  function automatic logic [8:0] abs9(input logic signed [8:0] v);
    return v[8] ? 9'(-v) : 9'(v);
  endfunction

endpackage

// File: rtl/laser_marker_draw.sv
// laser_marker_draw: emits a 3x3 marker centred on (tx, ty), one pixel per
// cycle for 9 cycles after a start pulse. Off-screen pixels still use their
// cycle but keep wren low. Outputs are registered and zero while idle.
//   clk, resetn    - clock, async active-low reset
//   start          - one-cycle pulse, begins a marker
//   tx, ty         - marker centre
//   wren/coord/colour - registered VGA pixel write
//   done           - high during the cycle the last pixel is issued
module laser_marker_draw
  import laser_pkg::*;
#(
  parameter logic [8:0] COLOUR = DEF_LASER_COLOUR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [7:0]  tx,
  input  logic [6:0]  ty,
  output logic        wren,
  output logic [14:0] coord,
  output logic [8:0]  colour,
  output logic        done
);

  localparam logic [9:0] XLIM = 10'(SCREEN_W);
  localparam logic [9:0] YLIM = 10'(SCREEN_H);

  logic       busy;
  logic [1:0] kx, ky;
  logic [9:0] px, py;

  // Offsets of -1 wrap to a huge unsigned value, so a single "< limit"
  // compare clips both the low and the high screen edge.
  assign px   = {2'b0, tx} + {8'b0, kx} - 10'd1;
  assign py   = {3'b0, ty} + {8'b0, ky} - 10'd1;
  assign done = busy && (kx == 2'd2) && (ky == 2'd2);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy   <= 1'b0;
      kx     <= 2'd0;
      ky     <= 2'd0;
      wren   <= 1'b0;
      coord  <= '0;
      colour <= '0;
    end else begin
      wren   <= 1'b0;
      coord  <= '0;
      colour <= '0;
      if (busy) begin
        wren   <= (px < XLIM) && (py < YLIM);
        coord  <= {px[7:0], py[6:0]};
        colour <= COLOUR;
        if (kx == 2'd2) begin
          kx <= 2'd0;
          ky <= ky + 2'd1;
        end else begin
          kx <= kx + 2'd1;
        end
        if (done) begin
          busy <= 1'b0;
          ky   <= 2'd0;
        end
      end else if (start) begin
        busy <= 1'b1;
        kx   <= 2'd0;
        ky   <= 2'd0;
      end
    end
  end

endmodule

// File: rtl/laser_targeting.sv
// laser_targeting: tower laser. Once per frame (outside cooldown) scans the
// four cars, shoots the first one in Chebyshev range, counts hits and flags
// destroyed cars; draws a 3x3 hit marker when granted the VGA draw slot.
//   clk, resetn         - clock, async active-low reset
//   initiate            - stage active; low clears all per-stage state
//   frame_tick          - one pulse per frame
//   car_N_coords        - {x, y} per car, 0 = not spawned
//   start_laser_draw    - draw slot grant pulse
//   destroyed_cars      - sticky destroyed flags
//   laser_wren/coord/colour - VGA pixel write
//   laser_done_drawing  - pulse when the draw slot is released
module laser_targeting
  import laser_pkg::*;
#(
  parameter logic [7:0] TOWER_X         = 8'd80,
  parameter logic [6:0] TOWER_Y         = 7'd60,
  parameter logic [7:0] RANGE           = 8'd40,
  parameter logic [1:0] HITS_TO_KILL    = 2'd3,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd15,
  parameter logic [8:0] LASER_COLOUR    = DEF_LASER_COLOUR
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        initiate,
  input  logic        frame_tick,
  input  logic [14:0] car_0_coords,
  input  logic [14:0] car_1_coords,
  input  logic [14:0] car_2_coords,
  input  logic [14:0] car_3_coords,
  input  logic        start_laser_draw,
  output logic [3:0]  destroyed_cars,
  output logic        laser_wren,
  output logic [14:0] coord,
  output logic [8:0]  colour,
  output logic        laser_done_drawing
);

  state_t            state, nstate;
  logic [1:0]        idx;
  logic [7:0]        tx;
  logic [6:0]        ty;
  logic [3:0][1:0]   hits;
  logic [7:0]        cooldown;
  logic              scan_pending, draw_pending, draw_req;
  logic              marker_start, marker_last;

  logic [3:0][14:0]  cars;
  logic [14:0]       cur;
  logic [7:0]        cx;
  logic [6:0]        cy;
  logic signed [8:0] ddx, ddy;
  logic              eligible;
  logic [1:0]        hit_next;

  assign cars = {car_3_coords, car_2_coords, car_1_coords, car_0_coords};
  assign cur  = cars[idx];
  assign cx   = cur[X_MSB:X_LSB];
  assign cy   = cur[Y_MSB:0];
  assign ddx  = $signed({1'b0, cx}) - $signed({1'b0, TOWER_X});
  assign ddy  = $signed({2'b0, cy}) - $signed({2'b0, TOWER_Y});

  assign eligible = !destroyed_cars[idx] && (cur != 15'd0) &&
                    (abs9(ddx) <= {1'b0, RANGE}) && (abs9(ddy) <= {1'b0, RANGE});

  assign hit_next = (hits[idx] == 2'd3) ? 2'd3 : hits[idx] + 2'd1;

  always_comb begin
    nstate       = state;
    marker_start = 1'b0;
    case (state)
      IDLE: begin
        if (draw_req) begin
          if (draw_pending) begin
            nstate       = DRAW;
            marker_start = 1'b1;
          end else begin
            nstate = DONE;
          end
        end else if (scan_pending) begin
          nstate = SCAN;
        end
      end
      SCAN:    if (eligible) nstate = FIRE; else if (idx == 2'd3) nstate = IDLE;
      FIRE:    nstate = IDLE;
      DRAW:    if (marker_last) nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
    // A marker already on its way must finish and release the draw chain.
    if (!initiate && state != DRAW && state != DONE) begin
      nstate       = IDLE;
      marker_start = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      idx                <= 2'd0;
      tx                 <= '0;
      ty                 <= '0;
      hits               <= '0;
      destroyed_cars     <= '0;
      cooldown           <= '0;
      scan_pending       <= 1'b0;
      draw_pending       <= 1'b0;
      draw_req           <= 1'b0;
      laser_done_drawing <= 1'b0;
    end else begin
      state              <= nstate;
      laser_done_drawing <= (state == DONE);

      if (frame_tick && cooldown != 8'd0) cooldown <= cooldown - 8'd1;

      case (state)
        IDLE: if (nstate == SCAN) begin
          idx          <= 2'd0;
          scan_pending <= 1'b0;
        end
        SCAN: begin
          if (eligible) begin
            tx <= cx;
            ty <= cy;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        FIRE: begin
          hits[idx] <= hit_next;
          if (hit_next >= HITS_TO_KILL) destroyed_cars[idx] <= 1'b1;
          cooldown     <= COOLDOWN_FRAMES;
          draw_pending <= 1'b1;
        end
        DRAW: if (nstate == DONE) draw_pending <= 1'b0;
        DONE: draw_req <= 1'b0;
        default: ;
      endcase

      // Requests are evaluated after the state actions so a new event in
      // the same cycle as a consume is never lost.
      if (start_laser_draw) draw_req <= 1'b1;
      if (frame_tick && initiate && cooldown == 8'd0) scan_pending <= 1'b1;

      if (!initiate) begin
        hits           <= '0;
        destroyed_cars <= '0;
        cooldown       <= '0;
        scan_pending   <= 1'b0;
        draw_pending   <= 1'b0;
        draw_req       <= 1'b0;
      end
    end
  end

  laser_marker_draw #(.COLOUR(LASER_COLOUR)) u_marker (
    .clk    (clk),
    .resetn (resetn),
    .start  (marker_start),
    .tx     (tx),
    .ty     (ty),
    .wren   (laser_wren),
    .coord  (coord),
    .colour (colour),
    .done   (marker_last)
  );

endmodule

// File: tb/tb_laser_targeting.sv
// tb_laser_targeting: frame-level reference model of the tower (targets,
// hits, cooldown, pending marker) driving directed and random scenarios.
// A second instance with the tower near the screen corner exercises clipping.
module tb_laser_targeting;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        initiate = 1'b0;
  logic        frame_tick = 1'b0;
  logic        start_laser_draw = 1'b0;
  logic [14:0] car [4];

  logic [3:0]  destroyed_cars, e_destroyed;
  logic        laser_wren, e_wren;
  logic [14:0] coord, e_coord;
  logic [8:0]  colour, e_colour;
  logic        laser_done_drawing, e_done;

  int checks = 0;
  int errors = 0;

  // model state
  int m_hits [4];
  bit m_dest [4];
  int m_cd;
  bit m_pend;
  int m_tx, m_ty;

  always #5 clk = ~clk;

  laser_targeting dut (
    .clk(clk), .resetn(resetn), .initiate(initiate), .frame_tick(frame_tick),
    .car_0_coords(car[0]), .car_1_coords(car[1]), .car_2_coords(car[2]), .car_3_coords(car[3]),
    .start_laser_draw(start_laser_draw), .destroyed_cars(destroyed_cars),
    .laser_wren(laser_wren), .coord(coord), .colour(colour),
    .laser_done_drawing(laser_done_drawing)
  );

  laser_targeting #(.TOWER_X(8'd20), .TOWER_Y(7'd100)) u_edge (
    .clk(clk), .resetn(resetn), .initiate(initiate), .frame_tick(frame_tick),
    .car_0_coords(car[0]), .car_1_coords(car[1]), .car_2_coords(car[2]), .car_3_coords(car[3]),
    .start_laser_draw(start_laser_draw), .destroyed_cars(e_destroyed),
    .laser_wren(e_wren), .coord(e_coord), .colour(e_colour),
    .laser_done_drawing(e_done)
  );

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic [3:0] m_dvec();
    return {m_dest[3], m_dest[2], m_dest[1], m_dest[0]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_hits[i] = 0;
      m_dest[i] = 0;
    end
    m_cd   = 0;
    m_pend = 0;
  endtask

  // One frame: either spend a cooldown frame or shoot the first car in range.
  task automatic model_tick();
    int x, y;
    bit found;
    if (m_cd > 0) begin
      m_cd--;
    end else begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        x = int'(car[i][14:7]);
        y = int'(car[i][6:0]);
        if (!found && !m_dest[i] && car[i] != 15'd0 &&
            iabs(x - 80) <= 40 && iabs(y - 60) <= 40) begin
          found = 1;
          m_hits[i] = (m_hits[i] < 3) ? m_hits[i] + 1 : 3;
          if (m_hits[i] >= 3) m_dest[i] = 1;
          m_cd   = 15;
          m_pend = 1;
          m_tx   = x;
          m_ty   = y;
        end
      end
    end
  endtask

  // Expected {wren, coord, colour} seen n cycles after the grant edge.
  function automatic logic [24:0] exp_px(input bit pend, input int tx, input int ty, input int n);
    int k, px, py;
    if (!pend || n < 2 || n > 10) return '0;
    k  = n - 2;
    px = tx + (k % 3) - 1;
    py = ty + (k / 3) - 1;
    if (px < 0 || px >= 160 || py < 0 || py >= 120) return '0;
    return {1'b1, px[7:0], py[6:0], 9'h1C0};
  endfunction

  task automatic do_grant(input string tag, input bit with_tick, input bit chk_edge,
                          input int etx, input int ety);
    bit pend;
    int tx, ty, dm, de;
    logic [24:0] om [14];
    logic [24:0] oe [14];
    pend = m_pend;
    tx   = m_tx;
    ty   = m_ty;
    m_pend = 0;
    if (with_tick) model_tick();
    dm = -1;
    de = -1;
    start_laser_draw = 1'b1;
    frame_tick       = with_tick;
    step();
    start_laser_draw = 1'b0;
    frame_tick       = 1'b0;
    for (int n = 1; n <= 13; n++) begin
      step();
      om[n] = {laser_wren, laser_wren ? coord : 15'd0, laser_wren ? colour : 9'd0};
      oe[n] = {e_wren, e_wren ? e_coord : 15'd0, e_wren ? e_colour : 9'd0};
      if (laser_done_drawing && dm < 0) dm = n;
      if (e_done && de < 0) de = n;
    end
    for (int n = 1; n <= 11; n++)
      chk($sformatf("%s px%0d", tag, n), 32'(om[n]), 32'(exp_px(pend, tx, ty, n)));
    chk($sformatf("%s done", tag), dm, pend ? 11 : 2);
    if (chk_edge) begin
      for (int n = 1; n <= 11; n++)
        chk($sformatf("%s edge px%0d", tag, n), 32'(oe[n]), 32'(exp_px(1, etx, ety, n)));
      chk($sformatf("%s edge done", tag), de, 11);
    end
  endtask

  task automatic do_tick(input bit grant);
    frame_tick = 1'b1;
    model_tick();
    step();
    frame_tick = 1'b0;
    repeat (10) step();
    chk("dest", destroyed_cars, m_dvec());
    if (grant) do_grant("mk", 0, 0, 0, 0);
  endtask

  task automatic drop_init();
    initiate = 1'b0;
    step();
    initiate = 1'b1;
    model_clear();
    step();
    chk("clr dest", destroyed_cars, 4'b0000);
  endtask

  function automatic logic [14:0] mk(input int x, input int y);
    return {x[7:0], y[6:0]};
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) car[i] = 15'd0;
    model_clear();
    m_tx = 0;
    m_ty = 0;
    step();
    step();
    chk("rst wren", laser_wren, 0);
    chk("rst coord", coord, 0);
    chk("rst colour", colour, 0);
    chk("rst done", laser_done_drawing, 0);
    chk("rst dest", destroyed_cars, 0);
    resetn   = 1'b1;
    initiate = 1'b1;
    step();

    // clipping at the corner on the second instance; main tower sees nothing in range
    car[0] = mk(0, 119);
    do_tick(0);
    do_grant("edge", 0, 1, 0, 119);

    // reset while a marker is half drawn
    drop_init();
    car[0] = 15'd0;
    car[1] = mk(80, 60);
    do_tick(0);
    start_laser_draw = 1'b1;
    step();
    start_laser_draw = 1'b0;
    repeat (6) step();
    chk("middraw wren", laser_wren, 1);
    chk("middraw coord", coord, mk(80, 60));
    resetn = 1'b0;
    #1;
    chk("async wren", laser_wren, 0);
    chk("async coord", coord, 0);
    chk("async colour", colour, 0);
    chk("async done", laser_done_drawing, 0);
    step();
    resetn = 1'b1;
    model_clear();
    step();
    do_grant("postrst", 0, 0, 0, 0);

    // three kills on car0, 16 frames apart
    car[1] = 15'd0;
    car[0] = 15'd11590;
    for (int t = 0; t < 33; t++) do_tick(1);
    chk("A dest", destroyed_cars, 4'b0001);

    // car0 out of range, car2 exactly on the range boundary
    car[0] = mk(10, 10);
    car[2] = mk(120, 100);
    for (int t = 0; t < 50; t++) do_tick(1);
    chk("B dest", destroyed_cars, 4'b0101);

    // initiate drop clears everything; next tick shoots at once
    drop_init();
    car[0] = 15'd11590;
    do_tick(1);
    chk("C hit", destroyed_cars, 4'b0000);

    // frame tick and grant together: old marker first, then the new shot
    car[0] = 15'd0;
    car[2] = 15'd0;
    car[1] = mk(100, 50);
    for (int t = 0; t < 15; t++) do_tick(0);
    do_tick(0);
    for (int t = 0; t < 15; t++) do_tick(0);
    car[1] = 15'd0;
    car[3] = mk(70, 40);
    do_grant("sim", 1, 0, 0, 0);
    repeat (10) step();
    chk("sim dest", destroyed_cars, m_dvec());
    do_grant("sim2", 0, 0, 0, 0);

    // random traffic
    for (int it = 0; it < 60; it++) begin
      if (it % 5 == 0) begin
        for (int i = 0; i < 4; i++)
          car[i] = ($urandom_range(0, 3) == 0) ? 15'd0 :
                   mk($urandom_range(25, 135), $urandom_range(5, 115));
      end
      if ($urandom_range(0, 11) == 0) drop_init();
      else do_tick(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
